// File: rtl/bias_relu.sv
// bias_relu: adds a per-column bias to a row-major HxW float matrix and
// applies ReLU. One shared single-precision adder (add_float, 2-cycle latency)
// is time-multiplexed across all elements by a small FSM.

module add_float (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_mode,
  output logic        o_done,
  output logic [31:0] o_result,
  output logic        o_overflow
);
  logic        r_v1;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_done;
  logic [31:0] r_res;
  logic        r_ovf;

  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic        w_swap, w_eff_sub, w_sign;
  logic [7:0]  w_ea, w_eb, w_el, w_es, w_d;
  logic [23:0] w_sl, w_ss;
  logic [26:0] w_ls, w_sx, w_ss_sh, w_norm;
  logic [27:0] w_sum;
  logic [4:0]  w_lz;
  logic [9:0]  w_exp, w_shift, w_efield;
  logic        w_rnd;
  logic [24:0] w_rsig;
  logic [22:0] w_mant;
  logic [31:0] w_res;
  logic        w_ovf;

  // Stage 1: capture operands; subtract mode folds into the sign of b
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_a  <= '0;
      r_b  <= '0;
    end else begin
      r_v1 <= i_start;
      if (i_start) begin
        r_a <= i_a;
        r_b <= i_b ^ {i_mode, 31'd0};
      end
    end
  end

  // Align, add, normalize and round-to-nearest-even on the captured operands
  always_comb begin
    w_a_nan   = (&r_a[30:23]) & (|r_a[22:0]);
    w_b_nan   = (&r_b[30:23]) & (|r_b[22:0]);
    w_a_inf   = (&r_a[30:23]) & ~(|r_a[22:0]);
    w_b_inf   = (&r_b[30:23]) & ~(|r_b[22:0]);
    // Denormals use an effective exponent of 1 with no hidden bit
    w_ea      = (r_a[30:23] == 8'd0) ? 8'd1 : r_a[30:23];
    w_eb      = (r_b[30:23] == 8'd0) ? 8'd1 : r_b[30:23];
    w_swap    = (r_b[30:0] > r_a[30:0]);
    w_el      = w_swap ? w_eb : w_ea;
    w_es      = w_swap ? w_ea : w_eb;
    w_sl      = w_swap ? {|r_b[30:23], r_b[22:0]} : {|r_a[30:23], r_a[22:0]};
    w_ss      = w_swap ? {|r_a[30:23], r_a[22:0]} : {|r_b[30:23], r_b[22:0]};
    w_sign    = w_swap ? r_b[31] : r_a[31];
    w_eff_sub = r_a[31] ^ r_b[31];
    w_d       = w_el - w_es;
    w_ls      = {w_sl, 3'b000};
    w_sx      = {w_ss, 3'b000};
    // Bits shifted out of the smaller operand collapse into the sticky bit
    if (w_d >= 8'd27) begin
      w_ss_sh = {26'd0, |w_ss};
    end else begin
      w_ss_sh = (w_sx >> w_d) | {26'd0, |(w_sx << (8'd27 - w_d))};
    end
    w_sum = w_eff_sub ? ({1'b0, w_ls} - {1'b0, w_ss_sh})
                      : ({1'b0, w_ls} + {1'b0, w_ss_sh});
    w_lz = 5'd27;
    for (int k = 0; k < 27; k++) begin
      if (w_sum[k]) w_lz = 5'(26 - k);
    end
    w_shift = 10'd0;
    if (w_sum[27]) begin
      w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_exp  = {2'b00, w_el} + 10'd1;
    end else begin
      // Never shift below the minimum exponent: the result becomes denormal
      w_shift = ({5'd0, w_lz} < ({2'b00, w_el} - 10'd1)) ? {5'd0, w_lz}
                                                        : ({2'b00, w_el} - 10'd1);
      w_norm  = w_sum[26:0] << w_shift;
      w_exp   = {2'b00, w_el} - w_shift;
    end
    w_rnd  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rsig = {1'b0, w_norm[26:3]} + {24'd0, w_rnd};
    if (w_rsig[24]) begin
      w_efield = w_exp + 10'd1;
      w_mant   = w_rsig[23:1];
    end else if (w_rsig[23]) begin
      w_efield = w_exp;
      w_mant   = w_rsig[22:0];
    end else begin
      w_efield = 10'd0;
      w_mant   = w_rsig[22:0];
    end
    w_ovf = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && w_eff_sub)) begin
      w_res = 32'h7fc00000;
    end else if (w_a_inf) begin
      w_res = r_a;
    end else if (w_b_inf) begin
      w_res = r_b;
    end else if (w_efield >= 10'd255) begin
      w_res = {w_sign, 8'hff, 23'd0};
      w_ovf = 1'b1;
    end else if ((w_sum == 28'd0) && w_eff_sub) begin
      // Exact cancellation yields +0
      w_res = 32'h00000000;
    end else begin
      w_res = {w_sign, w_efield[7:0], w_mant};
    end
  end

  // Stage 2: register the rounded result and its completion strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_res  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= r_v1;
      if (r_v1) begin
        r_res <= w_res;
        r_ovf <= w_ovf;
      end
    end
  end

  assign o_done     = r_done;
  assign o_result   = r_res;
  assign o_overflow = r_ovf;
endmodule

module bias_relu #(
  parameter int S = 32,
  parameter int H = 2,
  parameter int W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [S*H*W-1:0] mat,
  input  logic [S*W-1:0]   bias,
  output logic [S*H*W-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             nan_flag,
  output logic             overflow_flag
);
  localparam int N  = H * W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT, ST_WRITE, ST_FIN
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [S*N-1:0] r_mat;
  logic [S*W-1:0] r_bias;
  logic [IW-1:0]  r_idx;
  logic [CW-1:0]  r_col;
  logic           r_first_wait;
  logic [S-1:0]   r_sum;
  logic           r_sum_ovf;
  logic           r_busy;
  logic           r_done;
  logic           r_nan;
  logic           r_ovf;

  logic [S-1:0]   w_op1;
  logic [S-1:0]   w_op2;
  logic [31:0]    w_add_res;
  logic           w_add_start;
  logic           w_add_done;
  logic           w_add_ovf;
  logic           w_sum_nan;
  logic [S-1:0]   w_relu;
  logic           w_last;
  logic           w_capture;

  add_float u_add (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_add_start),
    .i_a        (w_op1),
    .i_b        (w_op2),
    .i_mode     (1'b0),
    .o_done     (w_add_done),
    .o_result   (w_add_res),
    .o_overflow (w_add_ovf)
  );

  assign w_last    = (r_idx == IW'(N - 1));
  assign w_capture = (r_state == ST_WAIT) && w_add_done && !r_first_wait;
  assign w_sum_nan = (&r_sum[30:23]) && (|r_sum[22:0]);
  // NaN passes through; any other negative (incl. -0, -inf) clamps to +0
  assign w_relu    = w_sum_nan ? r_sum : (r_sum[31] ? '0 : r_sum);

  // Select the current matrix element and its column bias
  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    for (int k = 0; k < N; k++) begin
      if (r_idx == IW'(k)) w_op1 = r_mat[S*(N-1-k) +: S];
    end
    for (int k = 0; k < W; k++) begin
      if (r_col == CW'(k)) w_op2 = r_bias[S*(W-1-k) +: S];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state and adder start strobe
  always_comb begin
    w_state_next = r_state;
    w_add_start  = 1'b0;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_ISSUE;
      ST_ISSUE: begin
        w_add_start  = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT:  if (w_capture) w_state_next = ST_WRITE;
      ST_WRITE: w_state_next = w_last ? ST_FIN : ST_ISSUE;
      ST_FIN:   w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Operand latch, element/column counters, sum capture and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mat        <= '0;
      r_bias       <= '0;
      r_idx        <= '0;
      r_col        <= '0;
      r_first_wait <= 1'b0;
      r_sum        <= '0;
      r_sum_ovf    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_nan        <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_first_wait <= (r_state == ST_ISSUE);
      r_busy       <= (w_state_next == ST_ISSUE) || (w_state_next == ST_WAIT) ||
                      (w_state_next == ST_WRITE);
      r_done       <= (w_state_next == ST_FIN);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mat  <= mat;
            r_bias <= bias;
            r_idx  <= '0;
            r_col  <= '0;
            r_nan  <= 1'b0;
            r_ovf  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (w_capture) begin
            r_sum     <= w_add_res;
            r_sum_ovf <= w_add_ovf;
          end
        end
        ST_WRITE: begin
          r_idx <= r_idx + 1'b1;
          r_col <= (r_col == CW'(W - 1)) ? '0 : r_col + 1'b1;
          if (w_sum_nan) r_nan <= 1'b1;
          if (r_sum_ovf) r_ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    logic [S-1:0] r_slot;

    // Each output slot changes only in the WRITE cycle of its own element
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_slot <= '0;
      end else if ((r_state == ST_WRITE) && (r_idx == IW'(gi))) begin
        r_slot <= w_relu;
      end
    end

    assign out[S*(N-gi)-1 -: S] = r_slot;
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign nan_flag      = r_nan;
  assign overflow_flag = r_ovf;
endmodule

// File: tb/tb_bias_relu.sv
// Directed testbench for bias_relu: hand-computed vectors for bias add,
// ReLU corner cases, flags, latency, ignored starts and mid-job reset.
module tb_bias_relu;
  localparam int S    = 32;
  localparam int H    = 2;
  localparam int W    = 2;
  localparam int N    = H * W;
  localparam int LADD = 2;
  localparam int LAT  = 1 + N * (2 + LADD);

  localparam logic [127:0] M_BASIC = {32'h40a00000, 32'h40000000, 32'hc0400000, 32'h3f000000};
  localparam logic [63:0]  B_BASIC = {32'h3f800000, 32'hbf800000};
  localparam logic [127:0] E_BASIC = {32'h40c00000, 32'h3f800000, 32'h00000000, 32'h00000000};
  localparam logic [127:0] M_NAN   = {32'h7fc00000, 32'h40000000, 32'hc0400000, 32'h3f000000};
  localparam logic [127:0] E_NAN   = {32'h7fc00000, 32'h3f800000, 32'h00000000, 32'h00000000};
  localparam logic [127:0] M_NZ    = {32'h3f800000, 32'h3f800000, 32'h40000000, 32'h80000000};
  localparam logic [63:0]  B_NZ    = {32'h3f800000, 32'h80000000};
  localparam logic [127:0] E_NZ    = {32'h40000000, 32'h3f800000, 32'h40400000, 32'h00000000};
  localparam logic [127:0] M_OV    = {32'h3f800000, 32'h7f7fffff, 32'h3f800000, 32'h3f800000};
  localparam logic [63:0]  B_OV    = {32'h3f800000, 32'h7f7fffff};
  localparam logic [127:0] E_OV    = {32'h40000000, 32'h7f800000, 32'h40000000, 32'h7f7fffff};
  localparam logic [127:0] M_ONES  = {32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] mat = '0;
  logic [63:0]  bias = '0;
  logic [127:0] out;
  logic         busy;
  logic         done;
  logic         nan_flag;
  logic         overflow_flag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bias_relu #(.S(S), .H(H), .W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mat           (mat),
    .bias          (bias),
    .out           (out),
    .busy          (busy),
    .done          (done),
    .nan_flag      (nan_flag),
    .overflow_flag (overflow_flag)
  );

  // Issue one job and wait (bounded) for done; inputs are scrambled after start
  task automatic run_job(input logic [127:0] m, input logic [63:0] b,
                         output int cyc, output logic busy1);
    @(negedge clk);
    mat = m; bias = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mat = ~m; bias = ~b;
    cyc = 1;
    busy1 = busy;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out !== 128'd0) begin errors++; $display("FAIL reset_out got %h want 0", out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (nan_flag !== 1'b0) begin errors++; $display("FAIL reset_nan got %b want 0", nan_flag); end
    checks++; if (overflow_flag !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow_flag); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    $display("reset: out=%h busy=%b done=%b", out, busy, done);
  endtask

  task automatic test_basic();
    int cyc; logic b1; logic [127:0] e;
    e = E_BASIC;
    run_job(M_BASIC, B_BASIC, cyc, b1);
    $display("job basic: cycles=%0d out=%h nan=%b ovf=%b", cyc, out, nan_flag, overflow_flag);
    checks++; if (cyc != LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", cyc, LAT); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got %b want 1", b1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (out[S*(N-k)-1 -: S] !== e[S*(N-k)-1 -: S]) begin
        errors++; $display("FAIL basic_out[%0d] got %h want %h", k, out[S*(N-k)-1 -: S], e[S*(N-k)-1 -: S]);
      end
    end
    checks++; if (nan_flag !== 1'b0) begin errors++; $display("FAIL basic_nan got %b want 0", nan_flag); end
    checks++; if (overflow_flag !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", overflow_flag); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
  endtask

  task automatic test_nan();
    int cyc; logic b1; logic [127:0] e;
    e = E_NAN;
    run_job(M_NAN, B_BASIC, cyc, b1);
    $display("job nan: cycles=%0d out=%h nan=%b ovf=%b", cyc, out, nan_flag, overflow_flag);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (out[S*(N-k)-1 -: S] !== e[S*(N-k)-1 -: S]) begin
        errors++; $display("FAIL nan_out[%0d] got %h want %h", k, out[S*(N-k)-1 -: S], e[S*(N-k)-1 -: S]);
      end
    end
    checks++; if (nan_flag !== 1'b1) begin errors++; $display("FAIL nan_flag got %b want 1", nan_flag); end
    checks++; if (overflow_flag !== 1'b0) begin errors++; $display("FAIL nan_ovf got %b want 0", overflow_flag); end
  endtask

  task automatic test_negzero();
    int cyc; logic b1; logic [127:0] e;
    e = E_NZ;
    run_job(M_NZ, B_NZ, cyc, b1);
    $display("job negzero: cycles=%0d out=%h nan=%b ovf=%b", cyc, out, nan_flag, overflow_flag);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (out[S*(N-k)-1 -: S] !== e[S*(N-k)-1 -: S]) begin
        errors++; $display("FAIL negzero_out[%0d] got %h want %h", k, out[S*(N-k)-1 -: S], e[S*(N-k)-1 -: S]);
      end
    end
    checks++; if (nan_flag !== 1'b0) begin errors++; $display("FAIL negzero_nan got %b want 0 (cleared at start)", nan_flag); end
  endtask

  task automatic test_overflow();
    int cyc; logic b1; logic [127:0] e;
    e = E_OV;
    run_job(M_OV, B_OV, cyc, b1);
    $display("job overflow: cycles=%0d out=%h nan=%b ovf=%b", cyc, out, nan_flag, overflow_flag);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (out[S*(N-k)-1 -: S] !== e[S*(N-k)-1 -: S]) begin
        errors++; $display("FAIL ovf_out[%0d] got %h want %h", k, out[S*(N-k)-1 -: S], e[S*(N-k)-1 -: S]);
      end
    end
    checks++; if (overflow_flag !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow_flag); end
    checks++; if (nan_flag !== 1'b0) begin errors++; $display("FAIL ovf_nan got %b want 0", nan_flag); end
  endtask

  task automatic test_back_to_back();
    int cyc_a, cyc_b; logic b1; logic [127:0] ea, eb;
    ea = E_NZ; eb = E_BASIC;
    run_job(M_NZ, B_NZ, cyc_a, b1);
    checks++; if (out !== ea) begin errors++; $display("FAIL b2b_first_out got %h want %h", out, ea); end
    run_job(M_BASIC, B_BASIC, cyc_b, b1);
    $display("job b2b: cycles=%0d,%0d out=%h", cyc_a, cyc_b, out);
    checks++; if (cyc_a != LAT) begin errors++; $display("FAIL b2b_lat_a got %0d want %0d", cyc_a, LAT); end
    checks++; if (cyc_b != LAT) begin errors++; $display("FAIL b2b_lat_b got %0d want %0d", cyc_b, LAT); end
    checks++; if (out !== eb) begin errors++; $display("FAIL b2b_second_out got %h want %h", out, eb); end
  endtask

  task automatic test_start_busy();
    int dn, first; logic [127:0] e;
    e = E_BASIC; dn = 0; first = 0;
    @(negedge clk);
    mat = M_BASIC; bias = B_BASIC; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    mat = M_ONES; bias = B_OV; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 3; c <= 45; c++) begin
      if (done === 1'b1) begin
        dn++;
        if (first == 0) first = c;
      end
      @(negedge clk);
    end
    $display("job start_busy: done_pulses=%0d first_done=%0d out=%h", dn, first, out);
    checks++; if (dn != 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", dn); end
    checks++; if (first != LAT) begin errors++; $display("FAIL busy_latency got %0d want %0d", first, LAT); end
    checks++; if (out !== e) begin errors++; $display("FAIL busy_out got %h want %h", out, e); end
  endtask

  task automatic test_reset_mid();
    int cyc; logic b1; logic [127:0] e;
    e = E_BASIC;
    @(negedge clk);
    mat = M_OV; bias = B_OV; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %b want 1", busy); end
    checks++; if (overflow_flag !== 1'b1) begin errors++; $display("FAIL rmid_ovf_before got %b want 1", overflow_flag); end
    rst_n = 1'b0;
    #1;
    checks++; if (out !== 128'd0) begin errors++; $display("FAIL rmid_out got %h want 0", out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (overflow_flag !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %b want 0", overflow_flag); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b want 0", done); end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_late_done got %b want 0", done); end
    end
    run_job(M_BASIC, B_BASIC, cyc, b1);
    $display("job after_reset: cycles=%0d out=%h", cyc, out);
    checks++; if (cyc != LAT) begin errors++; $display("FAIL rmid_new_latency got %0d want %0d", cyc, LAT); end
    checks++; if (out !== e) begin errors++; $display("FAIL rmid_new_out got %h want %h", out, e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nan();
    test_negzero();
    test_overflow();
    test_back_to_back();
    test_start_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
